video_loader: RTL

- Write-side initiator for the video buffer download port: accepts a byte stream from the download path, packs bytes into 32-bit words and issues them on the data_in/addr_in/data_write/data_ack four-phase handshake that the video block acknowledges.
- Sits between the HPS download interface and the video block.
- Addresses increment one word per write from a base, up to a frame word limit; the frame is bounded by a last-byte marker.

---
 rtl/video_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/video_loader.sv
// Packs a downloaded byte stream into little-endian 32-bit words and writes them to the video buffer.
// One write per word over a four-phase data_write/data_ack handshake; no bytes are taken while a write is in flight.
module video_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [14:0] MAX_WORDS = 15'd19200
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] data_out,
  output logic [31:0] addr_out,
  output logic        data_write,
  input  logic        data_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [14:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE_REQ,
    S_WRITE_REL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic [14:0] words_q, words_d;
  logic        ovf_q, ovf_d;
  logic        last_q, last_d;
  logic [31:0] merged;

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      acc_q   <= 32'd0;
      data_q  <= 32'd0;
      addr_q  <= 32'd0;
      words_q <= 15'd0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  // Insert the incoming byte into its lane; untouched lanes keep the accumulator (zero for fresh words).
  always_comb begin
    merged = acc_q;
    case (idx_q)
      2'd0:    merged[7:0]   = byte_data;
      2'd1:    merged[15:8]  = byte_data;
      2'd2:    merged[23:16] = byte_data;
      default: merged[31:24] = byte_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    data_d     = data_q;
    addr_d     = addr_q;
    words_d    = words_q;
    ovf_d      = ovf_q;
    last_d     = last_q;
    byte_ready = 1'b0;
    busy       = 1'b0;
    data_write = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          words_d = 15'd0;
          ovf_d   = 1'b0;
          idx_d   = 2'd0;
          acc_d   = 32'd0;
          last_d  = 1'b0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (idx_q == 2'd3 || byte_last) begin
            data_d  = merged;
            addr_d  = BASE_ADDR + {17'd0, words_q};
            last_d  = byte_last;
            acc_d   = 32'd0;
            idx_d   = 2'd0;
            state_d = S_WRITE_REQ;
          end else begin
            acc_d = merged;
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WRITE_REQ: begin
        busy       = 1'b1;
        data_write = 1'b1;
        if (data_ack) state_d = S_WRITE_REL;
      end
      S_WRITE_REL: begin
        busy = 1'b1;
        if (!data_ack) begin
          words_d = words_q + 15'd1;
          if (last_q) begin
            state_d = S_DONE;
          end else if (words_q + 15'd1 == MAX_WORDS) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_out      = data_q;
  assign addr_out      = addr_q;
  assign overflow      = ovf_q;
  assign words_written = words_q;

endmodule
